// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register pending-write scoreboard that raises a decode stall
//            on RAW hazards and on per-register counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_regwr,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic             wb_valid,
    input  logic             wb_regwr,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  busy_vec,
    output logic [TOT_W-1:0] inflight,
    output logic             err
);

    localparam int AW = 5;

    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [TOT_W-1:0]           inflight_q, inflight_d;
    logic                       err_q, err_d;

    logic             w_wb_fire, w_iss_fire, w_same_reg;
    logic             w_pend_rs1, w_pend_rs2, w_waw, w_accept;
    logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd, w_cnt_wb;
    logic             w_inc_eff, w_dec_eff;

    assign w_cnt_rs1 = cnt_q[issue_rs1];
    assign w_cnt_rs2 = cnt_q[issue_rs2];
    assign w_cnt_rd  = cnt_q[issue_rd];
    assign w_cnt_wb  = cnt_q[wb_rd];

    assign w_wb_fire = wb_valid && wb_regwr && (wb_rd != '0);

    // A register whose last outstanding write retires this cycle is readable,
    // since the register file writes before it is read.
    assign w_pend_rs1 = (issue_rs1 != '0) && (w_cnt_rs1 != '0) &&
                        !(w_wb_fire && (wb_rd == issue_rs1) && (w_cnt_rs1 == CNT_W'(1)));
    assign w_pend_rs2 = (issue_rs2 != '0) && (w_cnt_rs2 != '0) &&
                        !(w_wb_fire && (wb_rd == issue_rs2) && (w_cnt_rs2 == CNT_W'(1)));
    assign w_waw      = issue_regwr && (issue_rd != '0) && (&w_cnt_rd) &&
                        !(w_wb_fire && (wb_rd == issue_rd));

    assign stall = issue_valid && !flush &&
                   ((issue_use_rs1 && w_pend_rs1) || (issue_use_rs2 && w_pend_rs2) || w_waw);

    assign w_accept   = issue_valid && !stall && !flush;
    assign w_iss_fire = w_accept && issue_regwr && (issue_rd != '0);
    assign w_same_reg = w_iss_fire && w_wb_fire && (issue_rd == wb_rd);

    assign w_inc_eff = w_iss_fire && !w_same_reg;
    assign w_dec_eff = w_wb_fire && !w_same_reg && (w_cnt_wb != '0);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (w_inc_eff && (issue_rd == AW'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (w_dec_eff && (wb_rd == AW'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        inflight_d = inflight_q;
        err_d      = err_q;
        if (flush) begin
            inflight_d = '0;
            err_d      = 1'b0;
        end else begin
            if (w_inc_eff && !w_dec_eff) begin
                inflight_d = inflight_q + TOT_W'(1);
            end else if (!w_inc_eff && w_dec_eff) begin
                inflight_d = inflight_q - TOT_W'(1);
            end
            // Retiring a write nobody issued is sticky until the next flush.
            if (w_wb_fire && !w_same_reg && (w_cnt_wb == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        assign busy_vec[gi] = |cnt_q[gi];
    end

    assign inflight = inflight_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed vector table plus randomized model comparison for
//            reg_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 0, issue_regwr = 0, issue_use_rs1 = 0, issue_use_rs2 = 0;
    logic [4:0]  issue_rd = 0, issue_rs1 = 0, issue_rs2 = 0;
    logic        wb_valid = 0, wb_regwr = 0, flush = 0;
    logic [4:0]  wb_rd = 0;
    logic        stall, err;
    logic [31:0] busy_vec;
    logic [5:0]  inflight;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(32), .CNT_W(2), .TOT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_regwr(issue_regwr), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .busy_vec(busy_vec), .inflight(inflight), .err(err)
    );

    typedef struct {
        logic        iv, rw;
        logic [4:0]  rd, rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2, wv, wwr;
        logic [4:0]  wrd;
        logic        fl;
        logic        es;
        logic [31:0] eb;
        logic [5:0]  ei;
        logic        ee;
    } vec_t;

    function automatic vec_t mk(input logic iv, rw, input logic [4:0] rd, rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, wv, wwr,
                                input logic [4:0] wrd, input logic fl, es,
                                input logic [31:0] eb, input logic [5:0] ei, input logic ee);
        vec_t v;
        v.iv = iv; v.rw = rw; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.wv = wv; v.wwr = wwr; v.wrd = wrd; v.fl = fl;
        v.es = es; v.eb = eb; v.ei = ei; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_regwr = v.rw; issue_rd = v.rd;
        issue_rs1 = v.rs1; issue_use_rs1 = v.u1; issue_rs2 = v.rs2; issue_use_rs2 = v.u2;
        wb_valid = v.wv; wb_regwr = v.wwr; wb_rd = v.wrd; flush = v.fl;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1 check({tag, ".stall"}, {31'b0, stall}, {31'b0, v.es});
        @(posedge clk);
        #1;
        check({tag, ".busy"}, busy_vec, v.eb);
        check({tag, ".inflight"}, {26'b0, inflight}, {26'b0, v.ei});
        check({tag, ".err"}, {31'b0, err}, {31'b0, v.ee});
    endtask

    // Reference model: one pending count per register, totals derived by summing.
    int mcnt[32];
    bit merr;

    function automatic bit m_pend(input logic [4:0] r, input bit wbf, input logic [4:0] wrd);
        return (r != 0) && (mcnt[r] != 0) && !(wbf && wrd == r && mcnt[r] == 1);
    endfunction

    function automatic vec_t model_step(input vec_t v);
        vec_t o = v;
        bit wbf, st, isf;
        int tot;
        wbf = v.wv && v.wwr && (v.wrd != 0);
        st  = v.iv && !v.fl && ((v.u1 && m_pend(v.rs1, wbf, v.wrd)) ||
                                (v.u2 && m_pend(v.rs2, wbf, v.wrd)) ||
                                (v.rw && v.rd != 0 && mcnt[v.rd] == 3 && !(wbf && v.wrd == v.rd)));
        isf = v.iv && !st && !v.fl && v.rw && (v.rd != 0);
        if (v.fl) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            merr = 0;
        end else if (!(isf && wbf && v.rd == v.wrd)) begin
            if (isf) mcnt[v.rd]++;
            if (wbf) begin
                if (mcnt[v.wrd] > 0) mcnt[v.wrd]--;
                else merr = 1;
            end
        end
        tot = 0;
        o.eb = '0;
        foreach (mcnt[i]) begin
            tot += mcnt[i];
            if (mcnt[i] != 0) o.eb[i] = 1'b1;
        end
        o.es = st;
        o.ei = tot[5:0];
        o.ee = merr;
        return o;
    endfunction

    vec_t tbl[25];

    initial begin
        //              iv rw rd rs1 u1 rs2 u2 wv wwr wrd fl  es  eb          ei ee
        tbl[0]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h20,     1, 0);
        tbl[1]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  1, 32'h20,     1, 0);
        tbl[2]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  1, 32'h20,     1, 0);
        tbl[3]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  1, 32'h20,     1, 0);
        tbl[4]  = mk(1, 0, 0, 5, 1, 0, 0, 1, 1, 5, 0,  0, 32'h0,      0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 32'h0,      0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 32'h0,      0, 0);
        tbl[8]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,     1, 0);
        tbl[9]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,     2, 0);
        tbl[10] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,     3, 0);
        tbl[11] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h80,     3, 0);
        tbl[12] = mk(1, 1, 7, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80,     3, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0,  0, 32'h80,     3, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,     3, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0,      0, 0);
        tbl[16] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h8,      1, 0);
        tbl[17] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h8,      2, 0);
        tbl[18] = mk(1, 0, 0, 3, 1, 0, 0, 1, 1, 3, 0,  1, 32'h8,      1, 0);
        tbl[19] = mk(1, 0, 0, 3, 1, 0, 0, 1, 1, 3, 0,  0, 32'h0,      0, 0);
        tbl[20] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h2,      1, 0);
        tbl[21] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h6,      2, 0);
        tbl[22] = mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h16,     3, 0);
        tbl[23] = mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h16,     4, 0);
        tbl[24] = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0,      0, 0);

        #2;
        check("reset.stall", {31'b0, stall}, 32'd0);
        check("reset.busy", busy_vec, 32'd0);
        check("reset.inflight", {26'b0, inflight}, 32'd0);
        check("reset.err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("vec%0d", i));

        foreach (mcnt[i]) mcnt[i] = 0;
        merr = 0;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v.iv  = ($urandom_range(0, 99) < 70);
            v.rw  = $urandom_range(0, 1);
            v.rd  = 5'($urandom_range(0, 7));
            v.rs1 = 5'($urandom_range(0, 7));
            v.u1  = $urandom_range(0, 1);
            v.rs2 = 5'($urandom_range(0, 7));
            v.u2  = $urandom_range(0, 1);
            v.wv  = ($urandom_range(0, 99) < 45);
            v.wwr = ($urandom_range(0, 99) < 85);
            v.wrd = 5'($urandom_range(0, 7));
            v.fl  = ($urandom_range(0, 99) < 4);
            apply(model_step(v), $sformatf("rand%0d", n));
        end

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0,   0, 0), "pre_rst.flush");
        apply(mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 1, 0), "pre_rst.iss10");
        apply(mk(1, 1, 11, 0, 0, 0, 0, 1, 1, 12, 0, 0, 32'hC00, 2, 1), "pre_rst.iss11");
        @(negedge clk);
        drive(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        #1 check("midrst.pre_stall", {31'b0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.stall", {31'b0, stall}, 32'd0);
        check("midrst.busy", busy_vec, 32'd0);
        check("midrst.inflight", {26'b0, inflight}, 32'd0);
        check("midrst.err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-write scoreboard for the RISC-V pipeline. It tracks how many issued instructions still have a pending write to each architectural register.
- It is the stall-side counterpart to operand forwarding: when a source register still has an outstanding write that is not retiring this cycle, it stalls the instruction at issue/decode.
- Placement: between decode/issue and writeback. Issue sends rs1/rs2/rd; writeback sends retiring rd.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter. Max outstanding writes per register is 2^CNT_W-1.
- TOT_W, 6, width of the total in-flight write counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_regwr  in  1  instruction writes rd.
- issue_rd  in  5  destination register.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_use_rs1  in  1  rs1 is actually read.
- issue_use_rs2  in  1  rs2 is actually read.
- wb_valid  in  1  writeback retires an instruction this cycle.
- wb_regwr  in  1  retiring instruction writes wb_rd.
- wb_rd  in  5  retiring destination register.
- flush  in  1  synchronous squash of all in-flight work.
- stall  out  1  hold decode this cycle (combinational).
- busy_vec  out  NREG  bit i is 1 when cnt[i] != 0 (registered state).
- inflight  out  TOT_W  total pending writes across all registers.
- err  out  1  sticky underflow error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all cnt[i]=0, inflight=0, err=0, busy_vec=0.
  - stall reflects the cleared state, so stall=0.
- Definitions:
  - wb_fire = wb_valid & wb_regwr & (wb_rd!=0).
  - pend(r) = (r!=0) & (cnt[r]!=0) & !(wb_fire & wb_rd==r & cnt[r]==1).
  - The retiring-last-write case does not stall because the register file is write-before-read.
- stall = issue_valid & !flush & (h1 | h2 | waw), where:
  - h1 = issue_use_rs1 & pend(rs1).
  - h2 = issue_use_rs2 & pend(rs2).
  - waw = issue_regwr & (issue_rd!=0) & (cnt[issue_rd] == all-ones) & !(wb_fire & wb_rd==issue_rd). This is counter saturation.
- Accept and counter updates:
  - accept = issue_valid & !stall & !flush.
  - iss_fire = accept & issue_regwr & (issue_rd!=0).
- Counter update at posedge clk, per register r:
  - inc = iss_fire & issue_rd==r; dec = wb_fire & wb_rd==r.
  - inc & dec: cnt unchanged.
  - inc only: cnt+1. Saturation is prevented by waw, so it never wraps.
  - dec only with cnt!=0: cnt-1.
  - dec only with cnt==0: cnt stays 0 and err<=1 (underflow is never a wrap).
- inflight tracks the sum of all counters, updated by the same inc/dec rules: +1, -1, or unchanged. An underflow dec does not change inflight.
- flush=1 (synchronous): all cnt<=0, inflight<=0, err<=0 next cycle, overriding same-cycle inc/dec. The pipeline guarantees squashed instructions never reach writeback.
- x0: never stalls, never counted. Writes to x0 from issue or wb are ignored entirely.
- Latency:
  - stall is same-cycle combinational from inputs and state.
  - busy_vec and inflight reflect an accepted issue or wb one cycle later.
- Reset mid-operation: immediate clear, no pending state survives.

Test Plan:
- Issue x5 write (rd=5, regwr=1), next cycle issue use_rs1 rs1=5 with no wb -> stall=1, busy_vec[5]=1, inflight=1. Hold 3 cycles, then wb_rd=5 -> stall=0 that same wb cycle; cnt[5]=0 next cycle.
- Issue rd=0 regwr=1, then read rs2=0 -> stall=0 always, busy_vec=0, inflight=0. A wb with wb_rd=0 on an empty board -> err stays 0.
- Three back-to-back issues to rd=7 (CNT_W=2) -> cnt[7]=3, inflight=3. A fourth issue to rd=7 -> stall=1 by waw. The same fourth issue with wb_rd=7 in the same cycle -> stall=0 and cnt[7] stays 3.
- wb_rd=9 with cnt[9]=0 -> err=1 next cycle, cnt[9]=0, inflight unchanged. err stays 1 until flush, then returns to 0.
- Two writes pending to x3 (cnt=2); reader of x3 plus wb_rd=3 in one cycle -> stall=1 (cnt 2->1). Next cycle wb_rd=3 again -> stall=0.
- With inflight=4 spread over x1, x2, x4, assert flush while also presenting an issue to x8 -> stall=0, issue not counted. Next cycle busy_vec=0, inflight=0. Then assert rst_n=0 mid-stream -> all outputs 0 immediately.
